seg7_scan_decoder: RTL and testbench

//  Receive side of the multiplexed 7-segment display bus: snoops the active-low segment

---
 rtl/seg7_scan_decoder.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus and recovers per-digit BCD, dp and errors.
// Each stable, single-anode bus episode is captured exactly once.
module seg7_scan_decoder #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  err_flag,
  output logic                  frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    S_COUNT,
    S_HOLD
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DIGITS-1:0] s_an;
  logic [7:0]        s_seg;
  logic [DIGITS-1:0] sel;
  logic [DIGITS-1:0] seen, seen_n;
  logic [DIGITS-1:0] seen_or;
  logic [IW-1:0]     idx;
  logic [3:0]        dval;
  logic              dlegal;
  logic              dblank;
  logic              diff;
  logic              onehot;
  logic              cap;
  logic              full;

  assign sel    = ~s_an;
  assign onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign diff   = {an_in, seg_in} != {s_an, s_seg};

  // Single input register; everything downstream looks only at this sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_an  <= '1;
      s_seg <= 8'hFF;
    end else begin
      s_an  <= an_in;
      s_seg <= seg_in;
    end
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_COUNT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: count identical samples, capture once, hold until bus moves.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    unique case (state)
      S_COUNT: begin
        if (onehot && cnt == LAST) begin
          cap     = 1'b1;
          cnt_n   = '0;
          state_n = diff ? S_COUNT : S_HOLD;
        end else if (diff || !onehot) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (diff) begin
          state_n = S_COUNT;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_COUNT;
        cnt_n   = '0;
      end
    endcase
  end

  // Position of the single low anode in the sample.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an[i]) idx = IW'(i);
    end
  end

  // Segment pattern to BCD; blank and illegal patterns are told apart.
  always_comb begin
    dval   = 4'hE;
    dlegal = 1'b0;
    dblank = 1'b0;
    unique case (s_seg[6:0])
      7'b1000000: begin dval = 4'd0; dlegal = 1'b1; end
      7'b1111001: begin dval = 4'd1; dlegal = 1'b1; end
      7'b0100100: begin dval = 4'd2; dlegal = 1'b1; end
      7'b0110000: begin dval = 4'd3; dlegal = 1'b1; end
      7'b0011001: begin dval = 4'd4; dlegal = 1'b1; end
      7'b0010010: begin dval = 4'd5; dlegal = 1'b1; end
      7'b0000010: begin dval = 4'd6; dlegal = 1'b1; end
      7'b1111000: begin dval = 4'd7; dlegal = 1'b1; end
      7'b0000000: begin dval = 4'd8; dlegal = 1'b1; end
      7'b0010000: begin dval = 4'd9; dlegal = 1'b1; end
      7'b1111111: begin dval = 4'hF; dblank = 1'b1; end
      default:    begin dval = 4'hE; end
    endcase
  end

  // Frame mask: completion takes priority over clr so the pulse is kept.
  always_comb begin
    seen_or = seen | (cap ? sel : '0);
    full    = cap && (seen_or == '1);
    if (full)     seen_n = '0;
    else if (clr) seen_n = cap ? sel : '0;
    else          seen_n = seen_or;
  end

  // Output registers; an illegal capture beats a same-cycle clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_out  <= '1;
      digit_valid <= '0;
      dp_out      <= '0;
      err_flag    <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      seen       <= seen_n;
      frame_done <= full;
      if (clr) err_flag <= 1'b0;
      if (cap) begin
        digits_out[4*idx +: 4] <= dval;
        digit_valid[idx]       <= dlegal;
        dp_out[idx]            <= ~s_seg[7];
        if (!dlegal && !dblank) err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random episodes
// checked against an episode-level reference model.
module tb_seg7_scan_decoder;

  localparam int D  = 4;
  localparam int ST = 4;

  logic          clk;
  logic          rst;
  logic [7:0]    seg_in;
  logic [D-1:0]  an_in;
  logic          clr;
  logic [4*D-1:0] digits_out;
  logic [D-1:0]  digit_valid;
  logic [D-1:0]  dp_out;
  logic          err_flag;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(ST)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .clr(clr),
    .digits_out(digits_out), .digit_valid(digit_valid), .dp_out(dp_out),
    .err_flag(err_flag), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [6:0]   pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};
  logic [15:0]  m_dig;
  logic [D-1:0] m_val, m_dp, m_seen;
  logic         m_err, m_fd;
  logic [11:0]  last;
  logic         has_last, pend, captured;
  int           run;
  logic [3:0]   pend_an;
  logic [7:0]   pend_seg;

  // Model: an episode is a run of identical samples; the STABLE-th identical
  // sample of a single-digit episode schedules one capture for the next edge.
  task automatic model_edge(input logic [3:0] a, input logic [7:0] sg,
                            input logic c, input logic r);
    int d;
    int i;
    logic [3:0] bitm;
    if (r) begin
      m_dig = 16'hFFFF; m_val = '0; m_dp = '0; m_err = 0; m_fd = 0;
      m_seen = '0; has_last = 0; run = 0; pend = 0; captured = 0;
    end else begin
      m_fd = 0;
      if (pend) begin
        d = -1;
        for (int k = 0; k < 10; k++) if (pend_seg[6:0] == pat[k]) d = k;
        i = 0;
        for (int j = 0; j < D; j++) if (!pend_an[j]) i = j;
        bitm = ~pend_an;
        if (d >= 0) begin
          m_dig[4*i +: 4] = 4'(d); m_val[i] = 1'b1;
        end else if (pend_seg[6:0] == 7'h7F) begin
          m_dig[4*i +: 4] = 4'hF; m_val[i] = 1'b0;
        end else begin
          m_dig[4*i +: 4] = 4'hE; m_val[i] = 1'b0;
        end
        m_dp[i] = ~pend_seg[7];
        if (c) m_err = 0;
        if (d < 0 && pend_seg[6:0] != 7'h7F) m_err = 1;
        if ((m_seen | bitm) == 4'hF) begin
          m_fd = 1; m_seen = '0;
        end else begin
          m_seen = c ? bitm : (m_seen | bitm);
        end
      end else if (c) begin
        m_err = 0; m_seen = '0;
      end
      pend = 0;
      if (has_last && {a, sg} == last) run++;
      else begin run = 1; captured = 0; end
      last = {a, sg};
      has_last = 1;
      if (run >= ST && !captured && $countones(~a) == 1) begin
        pend = 1; pend_an = a; pend_seg = sg; captured = 1;
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, return at next negedge.
  task automatic cyc(input logic [3:0] a, input logic [7:0] sg,
                     input logic c, input logic r);
    an_in = a; seg_in = sg; clr = c; rst = r;
    @(posedge clk);
    model_edge(a, sg, c, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(4'hF, 8'hFF, 0, 1);
    cyc(4'hF, 8'hFF, 0, 1);
    checks++;
    if ({digits_out, digit_valid, dp_out, err_flag, frame_done} !==
        {16'hFFFF, 4'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h/%b/%b/%b/%b want ffff/0000/0000/0/0",
               digits_out, digit_valid, dp_out, err_flag, frame_done);
    end
  endtask

  task automatic test_single_digit();
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1110, 8'h99, 0, 0);
      if (i == 3) begin
        checks++;
        if (digits_out !== 16'hFFFF) begin
          errors++;
          $display("FAIL single_early: got %h want ffff", digits_out);
        end
      end
      if (i == 4) begin
        checks++;
        if ({digits_out, digit_valid, dp_out} !== {16'hFFF4, 4'b0001, 4'b0000}) begin
          errors++;
          $display("FAIL single_capture: got %h/%b/%b want fff4/0001/0000",
                   digits_out, digit_valid, dp_out);
        end
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] ans [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] sgs [4] = '{8'hF9, 8'hA4, 8'h30, 8'h99};
    int pulses = 0;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 8; i++) begin
        cyc(ans[d], sgs[d], 0, 0);
        if (frame_done) pulses++;
        checks++;
        if ({digits_out, digit_valid, dp_out, err_flag, frame_done} !==
            {m_dig, m_val, m_dp, m_err, m_fd}) begin
          errors++;
          $display("FAIL scan d%0d c%0d: got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                   d, i, digits_out, digit_valid, dp_out, err_flag, frame_done,
                   m_dig, m_val, m_dp, m_err, m_fd);
        end
      end
    end
    checks++;
    if ({digits_out, digit_valid, dp_out} !== {16'h4321, 4'b1111, 4'b0100}) begin
      errors++;
      $display("FAIL scan_final: got %h/%b/%b want 4321/1111/0100",
               digits_out, digit_valid, dp_out);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL scan_frame: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 6; i++) cyc(4'b1110, 8'hF8, 0, 0);
    checks++;
    if (digits_out[3:0] !== 4'd7) begin
      errors++;
      $display("FAIL glitch_pre: got %h want 7", digits_out[3:0]);
    end
    cyc(4'b1110, 8'hF9, 0, 0);
    cyc(4'b1110, 8'hF9, 0, 0);
    cyc(4'b1110, 8'hA4, 0, 0);
    cyc(4'b1110, 8'hA4, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1110, 8'hF9, 0, 0);
      checks++;
      if (digits_out[3:0] !== (i < 4 ? 4'd7 : 4'd1) || err_flag !== 1'b0) begin
        errors++;
        $display("FAIL glitch c%0d: got %h err=%b want %h err=0",
                 i, digits_out[3:0], err_flag, (i < 4 ? 4'd7 : 4'd1));
      end
    end
  endtask

  task automatic test_blank_illegal();
    for (int i = 0; i < 6; i++) cyc(4'b1101, 8'hFF, 0, 0);
    checks++;
    if ({digits_out[7:4], digit_valid[1], err_flag} !== {4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL blank: got %h/%b/%b want f/0/0",
               digits_out[7:4], digit_valid[1], err_flag);
    end
    for (int i = 0; i < 5; i++) cyc(4'b1101, 8'hC9, (i == 4), 0);
    checks++;
    if ({digits_out[7:4], digit_valid[1], err_flag} !== {4'hE, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL illegal_clr: got %h/%b/%b want e/0/1",
               digits_out[7:4], digit_valid[1], err_flag);
    end
    cyc(4'b1101, 8'hC9, 0, 0);
    cyc(4'b1101, 8'hC9, 1, 0);
    checks++;
    if ({digits_out[7:4], err_flag} !== {4'hE, 1'b0}) begin
      errors++;
      $display("FAIL clr_alone: got %h/%b want e/0", digits_out[7:4], err_flag);
    end
  endtask

  task automatic test_no_onehot();
    logic [15:0] sd;
    logic [3:0]  sv, sp;
    sd = m_dig; sv = m_val; sp = m_dp;
    for (int i = 0; i < 20; i++) begin
      cyc(i < 10 ? 4'b1100 : 4'b1111, 8'h99, 0, 0);
      checks++;
      if ({digits_out, digit_valid, dp_out, frame_done} !== {sd, sv, sp, 1'b0}) begin
        errors++;
        $display("FAIL no_onehot c%0d: got %h/%b/%b/%b want %h/%b/%b/0",
                 i, digits_out, digit_valid, dp_out, frame_done, sd, sv, sp);
      end
    end
    cyc(4'b1111, 8'h99, 0, 1);
    checks++;
    if ({digits_out, digit_valid, dp_out, err_flag, frame_done} !==
        {16'hFFFF, 4'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b/%b/%b/%b want ffff/0000/0000/0/0",
               digits_out, digit_valid, dp_out, err_flag, frame_done);
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [7:0] sg;
    int hold;
    int bad = 0;
    for (int e = 0; e < 400; e++) begin
      if ($urandom_range(0, 9) < 8) a = ~(4'b0001 << $urandom_range(0, 3));
      else a = 4'($urandom);
      case ($urandom_range(0, 5))
        0:       sg = 8'hFF;
        1:       sg = 8'($urandom);
        default: sg = {1'($urandom), pat[$urandom_range(0, 9)]};
      endcase
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) begin
        cyc(a, sg, ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
        checks++;
        if ({digits_out, digit_valid, dp_out, err_flag, frame_done} !==
            {m_dig, m_val, m_dp, m_err, m_fd}) begin
          errors++;
          if (bad < 10)
            $display("FAIL random e%0d c%0d: got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                     e, i, digits_out, digit_valid, dp_out, err_flag, frame_done,
                     m_dig, m_val, m_dp, m_err, m_fd);
          bad++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; an_in = '1; seg_in = 8'hFF; clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_digit();
    test_scan();
    test_glitch();
    test_blank_illegal();
    test_no_onehot();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
